// File: rtl/lutram_readback_streamer.sv
// Sweeps every address of a distributed RAM's async read port once per START,
// packs the 1-bit read data LSB-first into WORD-bit words and streams them out.
module lutram_readback_streamer #(
  parameter int ABITS = 6,
  parameter int WORD  = 8
) (
  input  logic             CLK1,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  output logic [ABITS-1:0] A1ADDR,
  input  logic             A1DATA,
  output logic [WORD-1:0]  M_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic             M_LAST,
  output logic             BUSY,
  output logic             DONE
);

  localparam int IW = $clog2(WORD);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(WORD - 1);
  localparam logic [ABITS-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WORD-2:0]  shift_q, shift_d;
  logic [WORD-1:0]  mdata_q, mdata_d;
  logic             mvalid_q, mvalid_d;
  logic             mlast_q, mlast_d;
  logic             done_q, done_d;
  logic             sample_en;
  logic             accept;
  logic             word_end;

  assign accept   = mvalid_q && M_READY;
  assign word_end = (idx_q == IDX_LAST);

  // The top bit of a word never lands in the shift register; it goes straight
  // into the output register together with the rest of the word.
  generate
    for (genvar gi = 0; gi < WORD - 1; gi++) begin : g_shift
      assign shift_d[gi] = (sample_en && idx_q == IW'(gi)) ? A1DATA : shift_q[gi];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    mdata_d   = mdata_q;
    mvalid_d  = mvalid_q;
    mlast_d   = mlast_q;
    done_d    = 1'b0;
    sample_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_READ;
          addr_d  = '0;
          idx_d   = '0;
        end
      end
      S_READ: begin
        if (ABORT) begin
          state_d  = S_IDLE;
          mvalid_d = 1'b0;
          mlast_d  = 1'b0;
          addr_d   = '0;
          idx_d    = '0;
        end else begin
          if (accept) begin
            mvalid_d = 1'b0;
            mlast_d  = 1'b0;
          end
          // Only the word-completing sample can stall on a full output register.
          if (!word_end || !mvalid_q || M_READY) begin
            sample_en = 1'b1;
            idx_d     = word_end ? '0 : idx_q + IW'(1);
            if (word_end) begin
              mdata_d  = {A1DATA, shift_q};
              mvalid_d = 1'b1;
              mlast_d  = (addr_q == ADDR_LAST);
            end
            if (addr_q == ADDR_LAST) begin
              state_d = S_DRAIN;
            end else begin
              addr_d = addr_q + ABITS'(1);
            end
          end
        end
      end
      S_DRAIN: begin
        if (ABORT) begin
          state_d  = S_IDLE;
          mvalid_d = 1'b0;
          mlast_d  = 1'b0;
          addr_d   = '0;
          idx_d    = '0;
        end else if (accept) begin
          state_d  = S_IDLE;
          mvalid_d = 1'b0;
          mlast_d  = 1'b0;
          done_d   = 1'b1;
          addr_d   = '0;
          idx_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK1) begin
    if (RST) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
      done_q   <= done_d;
    end
  end

  assign A1ADDR  = addr_q;
  assign M_DATA  = mdata_q;
  assign M_VALID = mvalid_q;
  assign M_LAST  = mlast_q;
  assign BUSY    = (state_q != S_IDLE);
  assign DONE    = done_q;

endmodule

// File: tb/tb_lutram_readback_streamer.sv
// Directed bench: a 64x1 streamer (WORD=8) and a 128x1 streamer (WORD=32),
// each reading a behavioural RAM with an async read port and an edge write port.
module tb_lutram_readback_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_start, a_abort, a_ready, a_valid, a_last, a_busy, a_done, a_rd;
  logic [5:0] a_addr;
  logic [7:0] a_data;
  logic b_start, b_abort, b_ready, b_valid, b_last, b_busy, b_done, b_rd;
  logic [6:0] b_addr;
  logic [31:0] b_data;

  logic [63:0]  ram_a, a_img;
  logic [127:0] ram_b, b_img;
  logic a_load, b_load, a_we, a_wd;
  logic [5:0] a_wa;

  assign a_rd = ram_a[a_addr];
  assign b_rd = ram_b[b_addr];

  always @(posedge clk) begin
    if (a_load) ram_a <= a_img;
    else if (a_we) ram_a[a_wa] <= a_wd;
    if (b_load) ram_b <= b_img;
  end

  lutram_readback_streamer #(.ABITS(6), .WORD(8)) dut_a (
    .CLK1(clk), .RST(rst), .START(a_start), .ABORT(a_abort),
    .A1ADDR(a_addr), .A1DATA(a_rd), .M_DATA(a_data), .M_VALID(a_valid),
    .M_READY(a_ready), .M_LAST(a_last), .BUSY(a_busy), .DONE(a_done)
  );

  lutram_readback_streamer #(.ABITS(7), .WORD(32)) dut_b (
    .CLK1(clk), .RST(rst), .START(b_start), .ABORT(b_abort),
    .A1ADDR(b_addr), .A1DATA(b_rd), .M_DATA(b_data), .M_VALID(b_valid),
    .M_READY(b_ready), .M_LAST(b_last), .BUSY(b_busy), .DONE(b_done)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0]  a_cap [16];
  logic        a_capl[16];
  int          a_n, a_dones;
  logic [31:0] b_cap [8];
  logic        b_capl[8];
  int          b_n, b_dones;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshakes are recorded from the stable pre-edge values, DONE after the edge.
  task automatic step();
    if (a_valid && a_ready && a_n < 16) begin
      a_cap[a_n] = a_data; a_capl[a_n] = a_last; a_n++;
    end
    if (b_valid && b_ready && b_n < 8) begin
      b_cap[b_n] = b_data; b_capl[b_n] = b_last; b_n++;
    end
    @(posedge clk); #1;
    if (a_done) a_dones++;
    if (b_done) b_dones++;
  endtask

  task automatic clr();
    a_n = 0; a_dones = 0; b_n = 0; b_dones = 0;
  endtask

  task automatic start_a();
    a_start = 1'b1; step(); a_start = 1'b0;
  endtask

  task automatic run_a(input string tag);
    int n = 0;
    while (!a_done && n < 300) begin step(); n++; end
    check(tag, a_done, 1'b1);
  endtask

  initial begin
    int e;
    rst = 1'b1;
    a_start = 0; a_abort = 0; a_ready = 0; a_we = 0; a_wd = 0; a_wa = '0;
    b_start = 0; b_abort = 0; b_ready = 0;
    for (int k = 0; k < 64; k++) a_img[k] = k[0];
    b_img = '1;
    a_load = 1; b_load = 1;
    clr();
    step(); step();
    a_load = 0; b_load = 0;
    rst = 1'b0;

    // reset state
    check("rst_addr", a_addr, 0);
    check("rst_data", a_data, 0);
    check("rst_valid", a_valid, 0);
    check("rst_last", a_last, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_b_busy", b_busy, 0);

    // ABORT alone in IDLE does nothing; START+ABORT in IDLE starts
    a_abort = 1; step();
    check("idle_abort_busy", a_busy, 0);
    a_start = 1; step(); a_start = 0;
    check("start_abort_busy", a_busy, 1);
    step(); a_abort = 0;
    check("abort_run_busy", a_busy, 0);

    // 1: full sweep, ready high
    clr(); a_ready = 1;
    start_a(); e = 0;
    check("t1_busy", a_busy, 1);
    check("t1_addr0", a_addr, 0);
    for (int i = 0; i < 7; i++) begin step(); e++; end
    check("t1_valid_e7", a_valid, 0);
    step(); e++;
    check("t1_valid_e8", a_valid, 1);
    check("t1_data_e8", a_data, 8'hAA);
    while (!a_done && e < 200) begin step(); e++; end
    check("t1_done_edge", e, 65);
    check("t1_busy_end", a_busy, 0);
    check("t1_words", a_n, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_word%0d", i), a_cap[i], 8'hAA);
      check($sformatf("t1_last%0d", i), a_capl[i], (i == 7) ? 1 : 0);
    end
    step();
    check("t1_done_pulse", a_done, 0);
    check("t1_dones", a_dones, 1);

    // 2: stall on the first word
    clr(); a_ready = 0;
    start_a();
    for (int i = 0; i < 8; i++) step();
    check("t2_valid", a_valid, 1);
    for (int i = 0; i < 10; i++) step();
    check("t2_addr_frozen", a_addr, 15);
    check("t2_data_hold", a_data, 8'hAA);
    check("t2_valid_hold", a_valid, 1);
    a_ready = 1;
    run_a("t2_done");
    check("t2_words", a_n, 8);
    check("t2_word0", a_cap[0], 8'hAA);
    check("t2_word1", a_cap[1], 8'hAA);
    check("t2_word7", a_cap[7], 8'hAA);
    check("t2_dones", a_dones, 1);

    // 3: 128x1, WORD=32, ready toggling
    clr(); b_ready = 1;
    b_start = 1; step(); b_start = 0;
    e = 0;
    while (!b_done && e < 400) begin b_ready = ~b_ready; step(); e++; end
    check("t3_done", b_done, 1);
    b_ready = 1;
    for (int i = 0; i < 3; i++) step();
    check("t3_words", b_n, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_word%0d", i), b_cap[i], 32'hFFFF_FFFF);
      check($sformatf("t3_last%0d", i), b_capl[i], (i == 3) ? 1 : 0);
    end
    check("t3_dones", b_dones, 1);
    check("t3_busy", b_busy, 0);

    // 4: abort at address 20 with a word pending
    clr(); a_ready = 1;
    start_a();
    for (int i = 0; i < 16; i++) step();
    a_ready = 0;
    for (int i = 0; i < 4; i++) step();
    check("t4_addr20", a_addr, 20);
    check("t4_pending", a_valid, 1);
    a_abort = 1; step(); a_abort = 0;
    check("t4_valid", a_valid, 0);
    check("t4_busy", a_busy, 0);
    check("t4_last", a_last, 0);
    for (int i = 0; i < 3; i++) step();
    check("t4_no_done", a_dones, 0);
    clr(); a_ready = 1;
    start_a();
    check("t4_restart_addr", a_addr, 0);
    for (int i = 0; i < 3; i++) step();
    check("t4_restart_addr3", a_addr, 3);
    run_a("t4_done");
    check("t4_words", a_n, 8);
    check("t4_word0", a_cap[0], 8'hAA);

    // 5: write to address 9 on the edge that samples it
    a_img[9] = 1'b0; a_load = 1; step(); a_load = 0;
    clr(); a_ready = 1;
    start_a();
    for (int i = 0; i < 9; i++) step();
    check("t5_addr9", a_addr, 9);
    a_we = 1; a_wa = 6'd9; a_wd = 1'b1;
    step();
    a_we = 0;
    run_a("t5_done");
    check("t5_word0", a_cap[0], 8'hAA);
    check("t5_word1_old", a_cap[1], 8'hA8);
    clr();
    start_a();
    run_a("t5_done2");
    check("t5_word1_new", a_cap[1], 8'hAA);

    // 6: START while busy, then reset mid-sweep
    clr(); a_ready = 1;
    start_a();
    for (int i = 0; i < 5; i++) step();
    a_start = 1;
    for (int i = 0; i < 3; i++) step();
    a_start = 0;
    check("t6_addr", a_addr, 8);
    run_a("t6_done");
    check("t6_words", a_n, 8);
    check("t6_dones", a_dones, 1);
    start_a();
    for (int i = 0; i < 10; i++) step();
    check("t6_busy_mid", a_busy, 1);
    rst = 1; step(); rst = 0;
    check("t6_rst_addr", a_addr, 0);
    check("t6_rst_data", a_data, 0);
    check("t6_rst_valid", a_valid, 0);
    check("t6_rst_last", a_last, 0);
    check("t6_rst_busy", a_busy, 0);
    check("t6_rst_done", a_done, 0);
    step();
    check("t6_stays_idle", a_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
